// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types, constants and baud helper for rx/tx cores.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_rx_state_t;

    function automatic int cycles_per_bit(int hz, int baud);
        return hz / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync2
// Description : Two-flop synchroniser for a single asynchronous input.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_meta <= RESET_VALUE;
            o_sync <= RESET_VALUE;
        end else begin
            r_meta <= i_async;
            o_sync <= r_meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_core
// Description : 8N1 UART receiver, mid-bit sampling, valid/ready byte output.
//               Define UART_RX_PARITY_EN to add an even-parity bit and
//               a sticky parity_error output.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLOCK_HZ       = 27_000_000,
    parameter int BAUD           = 115_200,
    parameter int CYCLES_PER_BIT = cycles_per_bit(CLOCK_HZ, BAUD)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_error,
    output logic                 overrun,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_error,
`endif
    input  logic                 clear_errors
);

    localparam int CNT_W = $clog2(CYCLES_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] c_cnt_half = CNT_W'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(DATA_BITS - 1);

    generate
        if (CYCLES_PER_BIT < 4) begin : g_cpb_check
            $error("uart_rx_core: CYCLES_PER_BIT must be at least 4");
        end
    endgenerate

    logic                 w_rx_s;
    logic                 w_tick;
    uart_rx_state_t       r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_deliver;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bad;
`endif

    uart_sync2 #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clock   (clock),
        .reset   (reset),
        .i_async (uart_rx),
        .o_sync  (w_rx_s)
    );

    assign w_tick = (r_state != IDLE) && (r_cnt == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_deliver   <= 1'b0;
            data        <= '0;
            valid       <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error <= 1'b0;
            r_par_bad    <= 1'b0;
`endif
        end else begin
            r_deliver <= 1'b0;

            // Clear first so that a same-cycle set below takes priority
            if (clear_errors) begin
                frame_error <= 1'b0;
                overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_error <= 1'b0;
`endif
            end

            if ((r_state != IDLE) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_cnt   <= c_cnt_half;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (w_rx_s) begin
                            r_state <= IDLE;
                        end else begin
                            r_cnt     <= c_cnt_full;
                            r_bit_idx <= '0;
                            r_state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        r_cnt     <= c_cnt_full;
                        r_bit_idx <= r_bit_idx + IDX_W'(1);
                        if (r_bit_idx == c_idx_last) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (w_tick) begin
                        r_cnt     <= c_cnt_full;
                        r_par_bad <= ^{r_shift, w_rx_s};
                        if (^{r_shift, w_rx_s}) begin
                            parity_error <= 1'b1;
                        end
                        r_state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (w_tick) begin
                        if (w_rx_s) begin
`ifdef UART_RX_PARITY_EN
                            r_deliver <= !r_par_bad;
`else
                            r_deliver <= 1'b1;
`endif
                            r_state <= IDLE;
                        end else begin
                            frame_error <= 1'b1;
                            r_state     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (w_rx_s) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // A byte arriving while the previous one is unconsumed is dropped
            if (r_deliver) begin
                if (!valid || ready) begin
                    data  <= r_shift;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_core
// Description : Directed self-checking bench for uart_rx_core (10 clocks/bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

    localparam int CPB = 10;
`ifdef UART_RX_PARITY_EN
    localparam int PX = CPB;
`else
    localparam int PX = 0;
`endif

    logic       clock;
    logic       reset;
    logic       uart_rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_error;
    logic       overrun;
    logic       clear_errors;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
`endif

    int n_pass  = 0;
    int n_total = 0;

    int         cyc         = 0;
    int         valid_rises = 0;
    int         valid_hi    = 0;
    int         rise_cyc    = 0;
    int         acc_cnt     = 0;
    logic [7:0] last_acc    = 8'h00;
    logic       prev_valid  = 1'b0;
    bit         saw_3c      = 1'b0;

    uart_rx_core #(
        .CLOCK_HZ (1000),
        .BAUD     (100)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .uart_rx      (uart_rx),
        .data         (data),
        .valid        (valid),
        .ready        (ready),
        .frame_error  (frame_error),
        .overrun      (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_error (parity_error),
`endif
        .clear_errors (clear_errors)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    // Observation of the output handshake, sampled mid-cycle
    always @(negedge clock) begin
        if (valid && !prev_valid) begin
            valid_rises++;
            rise_cyc = cyc;
        end
        if (valid) valid_hi++;
        prev_valid = valid;
        if (valid && ready) begin
            acc_cnt++;
            last_acc = data;
        end
        if (valid && data == 8'h3C) saw_3c = 1'b1;
    end

    task automatic drive_bit(input logic v);
        uart_rx = v;
        repeat (CPB) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic pflip);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ pflip);
`else
        if (pflip) uart_rx = 1'b1;
`endif
        drive_bit(stop);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_clear;
        clear_errors = 1'b1;
        idle_cycles(1);
        clear_errors = 1'b0;
    endtask

    task automatic test_reset;
        n_total++; if (data !== 8'h00) $display("FAIL reset_data got=%h exp=00", data); else n_pass++;
        n_total++; if (valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid); else n_pass++;
        n_total++; if (frame_error !== 1'b0) $display("FAIL reset_ferr got=%b exp=0", frame_error); else n_pass++;
        n_total++; if (overrun !== 1'b0) $display("FAIL reset_ovr got=%b exp=0", overrun); else n_pass++;
`ifdef UART_RX_PARITY_EN
        n_total++; if (parity_error !== 1'b0) $display("FAIL reset_perr got=%b exp=0", parity_error); else n_pass++;
`endif
    endtask

    task automatic test_basic;
        int vr0, vh0, t0, lat;
        ready = 1'b1;
        vr0 = valid_rises;
        vh0 = valid_hi;
        t0  = cyc;
        send_frame(8'h55, 1'b1, 1'b0);
        idle_cycles(5);
        lat = rise_cyc - t0;
        n_total++; if (valid_rises - vr0 !== 1) $display("FAIL basic_rises got=%0d exp=1", valid_rises - vr0); else n_pass++;
        n_total++; if (valid_hi - vh0 !== 1) $display("FAIL basic_pulse_width got=%0d exp=1", valid_hi - vh0); else n_pass++;
        n_total++; if (last_acc !== 8'h55) $display("FAIL basic_data got=%h exp=55", last_acc); else n_pass++;
        n_total++; if (lat < 97 + PX || lat > 100 + PX) $display("FAIL basic_latency got=%0d exp=%0d..%0d", lat, 97 + PX, 100 + PX); else n_pass++;
        n_total++; if (frame_error !== 1'b0 || overrun !== 1'b0) $display("FAIL basic_flags got=%b%b exp=00", frame_error, overrun); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int acc0;
        ready  = 1'b0;
        saw_3c = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle_cycles(5);
        n_total++; if (overrun !== 1'b1) $display("FAIL b2b_overrun got=%b exp=1", overrun); else n_pass++;
        n_total++; if (valid !== 1'b1 || data !== 8'hA5) $display("FAIL b2b_held got=%b/%h exp=1/a5", valid, data); else n_pass++;
        acc0 = acc_cnt;
        ready = 1'b1;
        idle_cycles(1);
        ready = 1'b0;
        n_total++; if (valid !== 1'b0) $display("FAIL b2b_consume got=%b exp=0", valid); else n_pass++;
        n_total++; if (last_acc !== 8'hA5 || acc_cnt - acc0 !== 1) $display("FAIL b2b_accepted got=%h/%0d exp=a5/1", last_acc, acc_cnt - acc0); else n_pass++;
        ready = 1'b1;
        idle_cycles(20);
        ready = 1'b0;
        n_total++; if (saw_3c !== 1'b0) $display("FAIL b2b_dropped_byte got=%b exp=0", saw_3c); else n_pass++;
        pulse_clear();
        n_total++; if (overrun !== 1'b0) $display("FAIL b2b_clear got=%b exp=0", overrun); else n_pass++;
    endtask

    task automatic test_frame_error;
        int vr0;
        ready = 1'b1;
        vr0 = valid_rises;
        send_frame(8'hF0, 1'b0, 1'b0);
        idle_cycles(30);
        n_total++; if (frame_error !== 1'b1) $display("FAIL ferr_flag got=%b exp=1", frame_error); else n_pass++;
        n_total++; if (valid_rises !== vr0) $display("FAIL ferr_no_valid got=%0d exp=%0d", valid_rises, vr0); else n_pass++;
        uart_rx = 1'b1;
        idle_cycles(20);
        send_frame(8'h12, 1'b1, 1'b0);
        idle_cycles(5);
        n_total++; if (valid_rises - vr0 !== 1 || last_acc !== 8'h12) $display("FAIL ferr_recover got=%0d/%h exp=1/12", valid_rises - vr0, last_acc); else n_pass++;
        pulse_clear();
        n_total++; if (frame_error !== 1'b0) $display("FAIL ferr_clear got=%b exp=0", frame_error); else n_pass++;
    endtask

    task automatic test_glitch;
        int vr0;
        ready = 1'b0;
        vr0 = valid_rises;
        uart_rx = 1'b0;
        idle_cycles(3);
        uart_rx = 1'b1;
        idle_cycles(30);
        n_total++; if (valid !== 1'b0 || valid_rises !== vr0) $display("FAIL glitch_valid got=%b/%0d exp=0/%0d", valid, valid_rises, vr0); else n_pass++;
        n_total++; if (frame_error !== 1'b0 || overrun !== 1'b0) $display("FAIL glitch_flags got=%b%b exp=00", frame_error, overrun); else n_pass++;
        // A real frame right after must still align correctly
        send_frame(8'h5A, 1'b1, 1'b0);
        idle_cycles(2);
        n_total++; if (valid !== 1'b1 || data !== 8'h5A) $display("FAIL glitch_next got=%b/%h exp=1/5a", valid, data); else n_pass++;
        ready = 1'b1;
        idle_cycles(1);
        ready = 1'b0;
    endtask

    task automatic test_ready_in_delivery;
        int acc0;
        ready = 1'b0;
        send_frame(8'h81, 1'b1, 1'b0);
        acc0 = acc_cnt;
        fork
            send_frame(8'h7E, 1'b1, 1'b0);
            begin
                repeat (98 + PX) @(posedge clock);
                #1 ready = 1'b1;
                @(posedge clock);
                #1 ready = 1'b0;
            end
        join
        idle_cycles(2);
        n_total++; if (data !== 8'h7E) $display("FAIL rdy_deliv_data got=%h exp=7e", data); else n_pass++;
        n_total++; if (valid !== 1'b1) $display("FAIL rdy_deliv_valid got=%b exp=1", valid); else n_pass++;
        n_total++; if (overrun !== 1'b0) $display("FAIL rdy_deliv_overrun got=%b exp=0", overrun); else n_pass++;
        n_total++; if (acc_cnt - acc0 !== 1 || last_acc !== 8'h81) $display("FAIL rdy_deliv_old got=%0d/%h exp=1/81", acc_cnt - acc0, last_acc); else n_pass++;
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] b;
        int vr0;
        b = 8'hC3;
        ready = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        uart_rx = b[4];
        reset = 1'b1;
        idle_cycles(2);
        n_total++; if (data !== 8'h00 || valid !== 1'b0) $display("FAIL midrst_out got=%h/%b exp=00/0", data, valid); else n_pass++;
        n_total++; if (frame_error !== 1'b0 || overrun !== 1'b0) $display("FAIL midrst_flags got=%b%b exp=00", frame_error, overrun); else n_pass++;
        uart_rx = 1'b1;
        reset = 1'b0;
        idle_cycles(20);
        send_frame(8'h99, 1'b1, 1'b0);
        idle_cycles(2);
        n_total++; if (valid !== 1'b1 || data !== 8'h99) $display("FAIL midrst_next got=%b/%h exp=1/99", valid, data); else n_pass++;
        ready = 1'b1;
        idle_cycles(1);
        ready = 1'b0;
`ifdef UART_RX_PARITY_EN
        vr0 = valid_rises;
        send_frame(8'h99, 1'b1, 1'b1);
        idle_cycles(5);
        n_total++; if (parity_error !== 1'b1) $display("FAIL parity_flag got=%b exp=1", parity_error); else n_pass++;
        n_total++; if (valid_rises !== vr0) $display("FAIL parity_no_valid got=%0d exp=%0d", valid_rises, vr0); else n_pass++;
        pulse_clear();
        n_total++; if (parity_error !== 1'b0) $display("FAIL parity_clear got=%b exp=0", parity_error); else n_pass++;
`else
        vr0 = valid_rises;
        idle_cycles(5);
        n_total++; if (valid_rises !== vr0 || valid !== 1'b0) $display("FAIL midrst_quiet got=%0d/%b exp=%0d/0", valid_rises, valid, vr0); else n_pass++;
`endif
    endtask

    initial begin
        reset        = 1'b1;
        uart_rx      = 1'b1;
        ready        = 1'b0;
        clear_errors = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        test_reset();
        reset = 1'b0;
        idle_cycles(5);
        test_basic();
        test_back_to_back();
        test_frame_error();
        test_glitch();
        test_ready_in_delivery();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
